// File: rtl/mux_arb_reg.sv
// N-channel registered mux/arbiter: explicit-select, round-robin or fixed-priority grant
// feeding a one-entry output register with valid/ready backpressure.
`timescale 1ns/1ps
module mux_arb_reg #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [1:0]           mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  chan_q, chan_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic             load;
    logic             gnt_vld;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    assign load = ~valid_q | out_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        case (mode)
            2'd0: begin
                for (int i = 0; i < NCH; i++) begin
                    if (sel == SELW'(i) && in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(i);
                    end
                end
            end
            2'd1: begin
                // Walk the search order backwards so the nearest successor of ptr is written last.
                for (int k = NCH; k >= 1; k--) begin
                    for (int i = 0; i < NCH; i++) begin
                        if (i == (int'(ptr_q) + k) % NCH && in_valid[i]) begin
                            gnt_vld = 1'b1;
                            gnt_idx = SELW'(i);
                        end
                    end
                end
            end
            2'd2: begin
                for (int i = NCH - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SELW'(i);
                    end
                end
            end
            default: begin
                gnt_vld = 1'b0;
            end
        endcase
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_idx == SELW'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (load && gnt_vld && !clr && gnt_idx == SELW'(i)) in_ready[i] = 1'b1;
        end
    end

    // Held state is only rewritten when load is true, so sel/mode glitches cannot reach it during a stall.
    always_comb begin
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (gnt_vld) begin
                data_d  = gnt_data;
                chan_d  = gnt_idx;
                valid_d = 1'b1;
                ptr_d   = gnt_idx;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ptr_q   <= SELW'(NCH - 1);
        end else begin
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;

endmodule
